if_fetch_unit: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the PC and drives a req/ack handshake to the instruction cache/memory. It delivers the fetched instruction and PC+4 to IF/ID, along with the stall and flush controls that IF/ID consumes. Redirects (taken branch, jump) come from the ID stage. Hazard holds come from the hazard unit.

---
 rtl/if_fetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the req/ack handshake to imem
// and feeds IF/ID. Define FETCH_TIMEOUT_EN to add the miss watchdog and HALT state.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        pc_hold_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] instr_o,
   output logic [31:0] nextInstrAddr_o,
   output logic        instr_valid_o,
   output logic        fetch_stall_o,
   output logic        flush_o,
   output logic        fetch_err_o
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef FETCH_TIMEOUT_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;
`endif

   state_t      state_r, state_nxt_s;
   logic [31:0] pc_r, pc_nxt_s;
   logic [31:0] pend_r, pend_nxt_s;
   logic        req_s, valid_s, stall_s, flush_s;
   logic        redirect_s;
   logic [31:0] target_s;

   // Branch wins over jump; low address bits are dropped to keep the PC word-aligned.
   assign redirect_s = branch_taken_i | jump_i;
   assign target_s   = branch_taken_i ? {branch_target_i[31:2], 2'b00}
                                      : {jump_target_i[31:2], 2'b00};

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic             err_r, err_nxt_s;
`endif

   // Next-state, next-PC and handshake decode.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      pend_nxt_s  = pend_r;
      req_s       = 1'b0;
      valid_s     = 1'b0;
      stall_s     = 1'b0;
      flush_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            stall_s = 1'b1;
            if (start_i) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            req_s = 1'b1;
            if (imem_ack_i) begin
               if (redirect_s) begin
                  flush_s  = 1'b1;
                  pc_nxt_s = target_s;
               end else begin
                  valid_s  = 1'b1;
                  pc_nxt_s = pc_hold_i ? pc_r : pc_r + 32'd4;
               end
            end else begin
               stall_s = 1'b1;
               if (redirect_s) begin
                  flush_s     = 1'b1;
                  pend_nxt_s  = target_s;
                  state_nxt_s = ST_DRAIN;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
         end
         ST_DRAIN: begin
            // The outstanding request must complete before the new PC goes out.
            req_s   = 1'b1;
            stall_s = 1'b1;
            if (redirect_s) begin
               flush_s    = 1'b1;
               pend_nxt_s = target_s;
            end else begin
               pend_nxt_s = pend_r;
            end
            if (imem_ack_i) begin
               pc_nxt_s    = redirect_s ? target_s : pend_r;
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
`ifdef FETCH_TIMEOUT_EN
         ST_HALT: begin
            stall_s     = 1'b1;
            state_nxt_s = ST_HALT;
         end
`endif
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase

`ifdef FETCH_TIMEOUT_EN
      cnt_nxt_s = cnt_r;
      err_nxt_s = err_r;
      if (req_s && !imem_ack_i) begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
         if (cnt_nxt_s == CNT_W'(TIMEOUT_CYCLES)) begin
            err_nxt_s   = 1'b1;
            state_nxt_s = ST_HALT;
         end else begin
            err_nxt_s = err_r;
         end
      end else if (req_s) begin
         cnt_nxt_s = '0;
      end else begin
         cnt_nxt_s = cnt_r;
      end
`endif
   end

   // State, PC and pending-target registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r <= ST_IDLE;
         pc_r    <= RESET_PC;
         pend_r  <= 32'd0;
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= (state_r == ST_IDLE) ? RESET_PC : pc_nxt_s;
         pend_r  <= pend_nxt_s;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   // Miss watchdog and its sticky error flag.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_r <= '0;
         err_r <= 1'b0;
      end else begin
         cnt_r <= cnt_nxt_s;
         err_r <= err_nxt_s;
      end
   end
   assign fetch_err_o = err_r;
`else
   assign fetch_err_o = 1'b0;
`endif

   // Outputs are forced low while reset is asserted, including the IDLE stall.
   assign imem_req_o      = rst_i & req_s;
   assign instr_valid_o   = rst_i & valid_s;
   assign fetch_stall_o   = rst_i & stall_s;
   assign flush_o         = rst_i & flush_s;
   assign instr_o         = (rst_i & valid_s) ? imem_data_i : 32'd0;
   assign imem_addr_o     = pc_r;
   assign nextInstrAddr_o = pc_r + 32'd4;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized and directed bench for if_fetch_unit against a transaction-level model.
module tb_if_fetch_unit;
   localparam int          TB_TIMEOUT  = 8;
   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        start_i = 1'b0, pc_hold_i = 1'b0;
   logic        branch_taken_i = 1'b0, jump_i = 1'b0, imem_ack_i = 1'b0;
   logic [31:0] branch_target_i = 32'd0, jump_target_i = 32'd0, imem_data_i = 32'd0;
   logic        imem_req_o, instr_valid_o, fetch_stall_o, flush_o, fetch_err_o;
   logic [31:0] imem_addr_o, instr_o, nextInstrAddr_o;

   int n_tests = 0;
   int n_fail  = 0;

   // model: mode 0 idle, 1 run, 2 drain, 3 halt
   int          m_mode;
   logic [31:0] m_pc, m_pend;
   int          m_miss;
   logic        m_err;

   logic [31:0] seen_addr;
   logic        seen_valid, seen_flush, seen_stall;

   if_fetch_unit #(.RESET_PC(TB_RESET_PC), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_hold_i(pc_hold_i),
      .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
      .jump_i(jump_i), .jump_target_i(jump_target_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
      .instr_o(instr_o), .nextInstrAddr_o(nextInstrAddr_o),
      .instr_valid_o(instr_valid_o), .fetch_stall_o(fetch_stall_o),
      .flush_o(flush_o), .fetch_err_o(fetch_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_pc   = TB_RESET_PC;
      m_pend = 32'd0;
      m_miss = 0;
      m_err  = 1'b0;
   endtask

   // Asserts reset mid-cycle; outputs must drop without waiting for a clock edge.
   task automatic do_reset();
      #3;
      rst_i = 1'b0;
      start_i = 1'b0; pc_hold_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0; imem_ack_i = 1'b0;
      #1;
      check_value("rst_req",   {31'd0, imem_req_o},    32'd0);
      check_value("rst_valid", {31'd0, instr_valid_o}, 32'd0);
      check_value("rst_stall", {31'd0, fetch_stall_o}, 32'd0);
      check_value("rst_flush", {31'd0, flush_o},       32'd0);
      check_value("rst_err",   {31'd0, fetch_err_o},   32'd0);
      check_value("rst_instr", instr_o,                32'd0);
      check_value("rst_pc",    imem_addr_o,            TB_RESET_PC);
      model_reset();
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
   endtask

   // One clock: drive, compare outputs mid-cycle, then advance the model at the edge.
   task automatic step(input bit st, input bit hold, input bit br, input logic [31:0] bt,
                       input bit jp, input logic [31:0] jt, input bit ack, input logic [31:0] data);
      logic        redir, active, e_valid;
      logic [31:0] tgt;
      #1;
      start_i = st; pc_hold_i = hold; branch_taken_i = br; branch_target_i = bt;
      jump_i = jp; jump_target_i = jt; imem_ack_i = ack; imem_data_i = data;
      redir   = br | jp;
      tgt     = (br ? bt : jt) & 32'hFFFF_FFFC;
      active  = (m_mode == 1) || (m_mode == 2);
      e_valid = (m_mode == 1) && ack && !redir;
      @(negedge clk_i);
      check_value("req",   {31'd0, imem_req_o},    {31'd0, active});
      check_value("addr",  imem_addr_o,            m_pc);
      check_value("next",  nextInstrAddr_o,        m_pc + 32'd4);
      check_value("valid", {31'd0, instr_valid_o}, {31'd0, e_valid});
      check_value("instr", instr_o,                e_valid ? data : 32'd0);
      check_value("flush", {31'd0, flush_o},       {31'd0, active && redir});
      check_value("stall", {31'd0, fetch_stall_o}, {31'd0, !((m_mode == 1) && ack)});
      check_value("err",   {31'd0, fetch_err_o},   {31'd0, m_err});
      seen_addr  = imem_addr_o;
      seen_valid = instr_valid_o;
      seen_flush = flush_o;
      seen_stall = fetch_stall_o;
      @(posedge clk_i);
      case (m_mode)
         0: if (st) m_mode = 1;
         1: begin
            if (ack) m_pc = redir ? tgt : (hold ? m_pc : m_pc + 32'd4);
            else if (redir) begin
               m_pend = tgt;
               m_mode = 2;
            end
         end
         2: begin
            if (redir) m_pend = tgt;
            if (ack) begin
               m_pc   = m_pend;
               m_mode = 1;
            end
         end
         default: ;
      endcase
`ifdef FETCH_TIMEOUT_EN
      if (active) begin
         if (ack) m_miss = 0;
         else begin
            m_miss++;
            if (m_miss == TB_TIMEOUT) begin
               m_err  = 1'b1;
               m_mode = 3;
            end
         end
      end
`endif
   endtask

   initial begin
      model_reset();
      @(posedge clk_i);
      do_reset();

      // start, then back-to-back hits with data = address
      step(1, 0, 0, 0, 0, 0, 1, 32'hDEAD_0000);
      check_value("idle_stall", {31'd0, seen_stall}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 0, 0, 1, 32'(i * 4));
         check_value("tp1_addr", seen_addr, 32'(i * 4));
         check_value("tp1_valid", {31'd0, seen_valid}, 32'd1);
      end
      step(0, 0, 0, 0, 1, 32'h8, 1, 32'h1111);          // jump back to 0x8
      // three-cycle miss at 0x8
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 0, 0, 32'h0);
         check_value("tp2_addr", seen_addr, 32'h8);
         check_value("tp2_stall", {31'd0, seen_stall}, 32'd1);
      end
      step(0, 0, 0, 0, 0, 0, 1, 32'hA5A5_0008);
      check_value("tp2_valid", {31'd0, seen_valid}, 32'd1);
      step(0, 0, 0, 0, 0, 0, 1, 32'h0C);
      check_value("tp2_next", seen_addr, 32'hC);
      // branch on a hit at 0x10
      step(0, 0, 1, 32'h40, 0, 0, 1, 32'h10);
      check_value("tp3_flush", {31'd0, seen_flush}, 32'd1);
      check_value("tp3_valid", {31'd0, seen_valid}, 32'd0);
      step(0, 0, 0, 0, 1, 32'h16, 1, 32'h40);            // unaligned jump target
      check_value("tp3_addr", seen_addr, 32'h40);
      // redirects stacked during a miss at 0x14
      step(0, 0, 0, 0, 1, 32'h80, 0, 32'h0);
      check_value("tp4_addr", seen_addr, 32'h14);
      step(0, 0, 1, 32'h100, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 0, 0, 1, 32'hBAD0_0014);
      check_value("tp4_drop", {31'd0, seen_valid}, 32'd0);
      check_value("tp4_hold", seen_addr, 32'h14);
      step(0, 0, 1, 32'h20, 1, 32'h300, 1, 32'h100);     // branch beats jump
      check_value("tp4_addr", seen_addr, 32'h100);
      // hold for two hits at 0x20
      step(0, 1, 0, 0, 0, 0, 1, 32'h20);
      step(0, 1, 0, 0, 0, 0, 1, 32'h20);
      step(0, 0, 0, 0, 0, 0, 1, 32'h20);
      check_value("tp5_addr", seen_addr, 32'h20);
      step(0, 1, 1, 32'h200, 0, 0, 1, 32'h24);
      check_value("tp5_addr2", seen_addr, 32'h24);
      step(0, 0, 0, 0, 0, 0, 1, 32'h200);
      check_value("tp5_brwins", seen_addr, 32'h200);

      // randomized traffic with periodic resets
      for (int k = 0; k < 1500; k++) begin
         if (k % 300 == 299) do_reset();
         step(($urandom % 4) == 0, ($urandom % 5) == 0,
              ($urandom % 8) == 0, $urandom, ($urandom % 8) == 0, $urandom,
              ($urandom % 3) != 0, $urandom);
      end

`ifdef FETCH_TIMEOUT_EN
      do_reset();
      step(1, 0, 0, 0, 0, 0, 0, 32'h0);
      for (int i = 0; i < TB_TIMEOUT + 3; i++) step(0, 0, 0, 0, 0, 0, 0, 32'h0);
      #2;
      check_value("to_err", {31'd0, fetch_err_o}, 32'd1);
      check_value("to_req", {31'd0, imem_req_o}, 32'd0);
      do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 32'h0);
`else
      do_reset();
      step(1, 0, 0, 0, 0, 0, 0, 32'h0);
      for (int i = 0; i < TB_TIMEOUT + 3; i++) step(0, 0, 0, 0, 0, 0, 0, 32'h0);
      #2;
      check_value("no_to_err", {31'd0, fetch_err_o}, 32'd0);
      check_value("no_to_req", {31'd0, imem_req_o}, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
